input_debouncer: RTL and testbench

//   Conditions a raw asynchronous level (push-button, switch, external strobe) into a clean,
//   clk-synchronous level that drives the d input of the flip-flop stage.

---
 rtl/input_debouncer_pkg.sv | 19 +
 rtl/input_debouncer_if.sv | 19 +
 rtl/input_debouncer_sync_chain.sv | 25 ++
 rtl/input_debouncer.sv | 139 +++++++++++++
 tb/tb_input_debouncer.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/input_debouncer_pkg.sv
// Shared definitions for the input debouncer: state encodings, reset level, helpers.
package input_debouncer_pkg;

    localparam int unsigned DB_STATE_W = 2;
    localparam logic        DB_RST_LEVEL = 1'b1;

    typedef enum logic [DB_STATE_W-1:0] {
        ST_HIGH      = 2'b00,
        ST_WAIT_LOW  = 2'b01,
        ST_LOW       = 2'b10,
        ST_WAIT_HIGH = 2'b11
    } db_state_t;

    // True in the two settled states, false while a change is being qualified.
    function automatic logic is_stable(input db_state_t st);
        return (st == ST_HIGH) || (st == ST_LOW);
    endfunction

endpackage

// File: rtl/input_debouncer_if.sv
// Raw level in, conditioned level and status out.
interface input_debouncer_if;
    logic raw_in;
    logic d_out;
    logic d_out_bar;
    logic stable;
    logic rise_pulse;
    logic fall_pulse;

    modport master (
        output raw_in,
        input  d_out, d_out_bar, stable, rise_pulse, fall_pulse
    );

    modport slave (
        input  raw_in,
        output d_out, d_out_bar, stable, rise_pulse, fall_pulse
    );
endinterface

// File: rtl/input_debouncer_sync_chain.sv
// N-flop synchronizer with asynchronous active-low reset to RST_VAL.
module sync_chain #(
    parameter int unsigned N       = 2,
    parameter logic        RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [N-1:0] r_sync;

    // Shift the raw level through N flops toward o_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {N{RST_VAL}};
        end else begin
            r_sync <= {r_sync[N-2:0], i_d};
        end
    end

    assign o_q = r_sync[N-1];

endmodule

// File: rtl/input_debouncer.sv
// Synchronizer plus counter-based debounce FSM producing a clean level and its complement.
// Optional feature: define DEBOUNCER_EDGE_EN to enable registered rise/fall pulses;
// otherwise the pulse outputs are tied to 0 and no edge flops exist.
module input_debouncer
    import input_debouncer_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = 16
) (
    input  logic                 clk,
    input  logic                 preset,
    input_debouncer_if.slave     db_if
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             w_sync;
    db_state_t        r_state;
    db_state_t        w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_d_out;
    logic             r_d_out_bar;
    logic             r_stable;
    logic             w_d_out_nxt;
    logic             w_stable_nxt;

    sync_chain #(
        .N       (SYNC_STAGES),
        .RST_VAL (DB_RST_LEVEL)
    ) u_sync (
        .clk   (clk),
        .rst_n (preset),
        .i_d   (db_if.raw_in),
        .o_q   (w_sync)
    );

    // State, counter and output registers.
    always_ff @(posedge clk or negedge preset) begin
        if (!preset) begin
            r_state     <= ST_HIGH;
            r_cnt       <= '0;
            r_d_out     <= DB_RST_LEVEL;
            r_d_out_bar <= ~DB_RST_LEVEL;
            r_stable    <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_d_out     <= w_d_out_nxt;
            r_d_out_bar <= ~w_d_out_nxt;
            r_stable    <= w_stable_nxt;
        end
    end

    // Next state and counter: qualify a new level, drop back on any reversal.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_HIGH: begin
                if (!w_sync) begin
                    w_state_nxt = ST_WAIT_LOW;
                    w_cnt_nxt   = '0;
                end
            end
            ST_WAIT_LOW: begin
                if (w_sync) begin
                    w_state_nxt = ST_HIGH;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = ST_LOW;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_LOW: begin
                if (w_sync) begin
                    w_state_nxt = ST_WAIT_HIGH;
                    w_cnt_nxt   = '0;
                end
            end
            ST_WAIT_HIGH: begin
                if (!w_sync) begin
                    w_state_nxt = ST_LOW;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = ST_HIGH;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_HIGH;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Output decode of the next state; level only moves on entry to a settled state.
    always_comb begin
        w_d_out_nxt  = r_d_out;
        w_stable_nxt = is_stable(w_state_nxt);
        if (w_state_nxt == ST_HIGH) begin
            w_d_out_nxt = 1'b1;
        end else if (w_state_nxt == ST_LOW) begin
            w_d_out_nxt = 1'b0;
        end
    end

    assign db_if.d_out     = r_d_out;
    assign db_if.d_out_bar = r_d_out_bar;
    assign db_if.stable    = r_stable;

`ifdef DEBOUNCER_EDGE_EN
    logic r_rise;
    logic r_fall;

    // Edge pulses coincide with the cycle in which d_out first shows its new level.
    always_ff @(posedge clk or negedge preset) begin
        if (!preset) begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_rise <= ~r_d_out & w_d_out_nxt;
            r_fall <= r_d_out & ~w_d_out_nxt;
        end
    end

    assign db_if.rise_pulse = r_rise;
    assign db_if.fall_pulse = r_fall;
`else
    assign db_if.rise_pulse = 1'b0;
    assign db_if.fall_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_input_debouncer.sv
module tb_input_debouncer;

    localparam int unsigned SS = 2;
    localparam int unsigned DC = 4;
`ifdef DEBOUNCER_EDGE_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    logic clk    = 1'b0;
    logic preset = 1'b1;

    input_debouncer_if bus();

    input_debouncer #(
        .SYNC_STAGES     (SS),
        .DEBOUNCE_CYCLES (DC),
        .CNT_W           (16)
    ) dut (
        .clk    (clk),
        .preset (preset),
        .db_if  (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference: debounced level flips once the synchronized input has disagreed
    // with it for DC+1 consecutive edges; any agreement resets the run.
    bit m_level;
    int m_run;
    bit m_rise;
    bit m_fall;
    bit m_hist[$];

    function automatic void model_reset();
        m_level = 1'b1;
        m_run   = 0;
        m_rise  = 1'b0;
        m_fall  = 1'b0;
        m_hist.delete();
        for (int i = 0; i < int'(SS); i++) m_hist.push_back(1'b1);
    endfunction

    function automatic void model_edge(input bit raw);
        bit s;
        s = m_hist.pop_front();
        m_hist.push_back(raw);
        m_rise = 1'b0;
        m_fall = 1'b0;
        if (s != m_level) begin
            m_run++;
            if (m_run == int'(DC) + 1) begin
                m_level = s;
                m_run   = 0;
                m_rise  = s;
                m_fall  = !s;
            end
        end else begin
            m_run = 0;
        end
    endfunction

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".d_out"},      bus.d_out,      m_level);
        chk({tag, ".d_out_bar"},  bus.d_out_bar,  !m_level);
        chk({tag, ".stable"},     bus.stable,     m_run == 0);
        chk({tag, ".rise_pulse"}, bus.rise_pulse, m_rise & EDGE_EN);
        chk({tag, ".fall_pulse"}, bus.fall_pulse, m_fall & EDGE_EN);
    endtask

    task automatic step(input bit raw, input string tag);
        @(negedge clk);
        bus.raw_in = raw;
        @(posedge clk);
        model_edge(raw);
        #1;
        chk_model(tag);
    endtask

    typedef struct {
        bit raw;
        bit d_out;
        bit stable;
        bit fall;
    } vec_t;

    vec_t tbl[9];

    int n_fall;
    int n_rise;
    int n_change;
    int change_edge;
    bit prev_d;
    bit saw_unstable;

    initial begin
        // Edge-by-edge expectations for a held 1->0 change.
        for (int i = 0; i < 9; i++) begin
            tbl[i].raw    = 1'b0;
            tbl[i].d_out  = (i < 6);
            tbl[i].stable = (i < 2) || (i >= 6);
            tbl[i].fall   = (i == 6);
        end

        // Scenario 1: reset with raw_in low, then hold high.
        bus.raw_in = 1'b0;
        #1 preset = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst.d_out",      bus.d_out,      1'b1);
        chk("rst.d_out_bar",  bus.d_out_bar,  1'b0);
        chk("rst.stable",     bus.stable,     1'b1);
        chk("rst.rise_pulse", bus.rise_pulse, 1'b0);
        chk("rst.fall_pulse", bus.fall_pulse, 1'b0);
        @(negedge clk);
        bus.raw_in = 1'b1;
        preset = 1'b1;
        for (int i = 0; i < 20; i++) step(1'b1, "s1");

        // Scenario 2: table-driven timing of an accepted fall.
        for (int i = 0; i < 9; i++) begin
            step(tbl[i].raw, "s2m");
            chk($sformatf("s2.edge%0d.d_out", i + 1),  bus.d_out,      tbl[i].d_out);
            chk($sformatf("s2.edge%0d.stable", i + 1), bus.stable,     tbl[i].stable);
            chk($sformatf("s2.edge%0d.fall", i + 1),   bus.fall_pulse, tbl[i].fall & EDGE_EN);
        end

        // Scenario 5: reset asserted while qualifying a rise.
        for (int i = 0; i < 3; i++) step(1'b1, "s5pre");
        chk("s5.in_wait_high.stable", bus.stable, 1'b0);
        chk("s5.in_wait_high.d_out",  bus.d_out,  1'b0);
        @(negedge clk);
        #2 preset = 1'b0;
        #1;
        model_reset();
        chk("s5.rst.d_out",      bus.d_out,      1'b1);
        chk("s5.rst.d_out_bar",  bus.d_out_bar,  1'b0);
        chk("s5.rst.stable",     bus.stable,     1'b1);
        chk("s5.rst.rise_pulse", bus.rise_pulse, 1'b0);
        @(negedge clk);
        preset = 1'b1;
        for (int i = 0; i < 10; i++) step(1'b1, "s5post");

        // Scenario 3: short low glitch is rejected.
        n_change = 0;
        saw_unstable = 1'b0;
        prev_d = bus.d_out;
        for (int i = 0; i < 14; i++) begin
            step(i < 4 ? 1'b0 : 1'b1, "s3");
            if (bus.d_out !== prev_d) n_change++;
            if (bus.stable === 1'b0) saw_unstable = 1'b1;
            prev_d = bus.d_out;
        end
        chk_int("s3.d_out_changes", n_change, 0);
        chk("s3.stable_dipped", saw_unstable, 1'b1);
        chk("s3.stable_end",    bus.stable,   1'b1);

        // Scenario 4: bouncing then settling low.
        n_fall = 0;
        n_change = 0;
        change_edge = -1;
        prev_d = bus.d_out;
        for (int i = 0; i < 12; i++) begin
            step(((i / 2) % 2) == 0 ? 1'b0 : 1'b1, "s4bounce");
            if (bus.d_out !== prev_d) n_change++;
            if (bus.fall_pulse === 1'b1) n_fall++;
            prev_d = bus.d_out;
        end
        for (int i = 0; i < 12; i++) begin
            step(1'b0, "s4settle");
            if (bus.d_out !== prev_d) begin
                n_change++;
                change_edge = i + 1;
            end
            if (bus.fall_pulse === 1'b1) n_fall++;
            prev_d = bus.d_out;
        end
        chk_int("s4.d_out_changes", n_change, 1);
        chk_int("s4.change_edge", change_edge, int'(SS + DC + 1));
        chk_int("s4.fall_pulses", n_fall, EDGE_EN ? 1 : 0);

        // Randomized bursts of varying length against the reference.
        n_rise = 0;
        n_fall = 0;
        for (int b = 0; b < 300; b++) begin
            bit lvl;
            int len;
            lvl = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 10));
            for (int i = 0; i < len; i++) begin
                step(lvl, "rnd");
                if (m_rise) n_rise++;
                if (m_fall) n_fall++;
            end
        end
        $display("random phase: %0d rises, %0d falls in the reference", n_rise, n_fall);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
